// File: rtl/mode_controller_pkg.sv
// Shared encodings for the watch mode controller: FSM states, mux select codes,
// button-edge and strobe bundles, and small helpers for select lookup and mode advance.
package mode_controller_pkg;

  typedef enum logic [2:0] {
    ST_MODE_12    = 3'd0,
    ST_MODE_24    = 3'd1,
    ST_MODE_TIMER = 3'd2,
    ST_MODE_SW    = 3'd3,
    ST_ALERT      = 3'd4
  } state_t;

  // Select codes follow the mux_4to1 input order
  localparam logic [1:0] SEL_MODE_12    = 2'b00;
  localparam logic [1:0] SEL_MODE_24    = 2'b01;
  localparam logic [1:0] SEL_MODE_TIMER = 2'b10;
  localparam logic [1:0] SEL_MODE_SW    = 2'b11;

  typedef struct packed {
    logic sel;
    logic toggle;
    logic add_one;
    logic add_ten;
  } btn_edges_t;

  typedef struct packed {
    logic timer_toggle;
    logic sw_toggle;
    logic timer_add_one;
    logic timer_add_ten;
  } strobes_t;

  function automatic logic [1:0] select_of(state_t s);
    case (s)
      ST_MODE_12:    return SEL_MODE_12;
      ST_MODE_24:    return SEL_MODE_24;
      ST_MODE_SW:    return SEL_MODE_SW;
      default:       return SEL_MODE_TIMER;
    endcase
  endfunction

  function automatic state_t advance_mode(state_t s);
    case (s)
      ST_MODE_12:    return ST_MODE_24;
      ST_MODE_24:    return ST_MODE_TIMER;
      ST_MODE_TIMER: return ST_MODE_SW;
      default:       return ST_MODE_12;
    endcase
  endfunction

endpackage

// File: rtl/mode_controller_edge_pulse.sv
// Rising-edge detector with a registered history bit that resets high, so a level
// already high when reset releases never reports an edge.
module mode_controller_edge_pulse (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_level,
  output logic o_edge_c
);

  logic r_hist;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_hist <= 1'b1;
    else         r_hist <= i_level;
  end

  assign o_edge_c = i_level & ~r_hist;

endmodule

// File: rtl/mode_controller.sv
// Watch display sequencer: owns the mux select, routes button edges as 1-cycle strobes,
// raises a blinking alert on timer expiry and falls back to the 12-hour clock when idle.
module mode_controller
  import mode_controller_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT_MS = 30000,
  parameter int unsigned ALERT_MS        = 5000,
  parameter int unsigned BLINK_MS        = 250
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_khz_tick,
  input  logic       i_select_btn,
  input  logic       i_toggle_btn,
  input  logic       i_add_one_btn,
  input  logic       i_add_ten_btn,
  input  logic       i_timer_running,
  input  logic       i_timer_expired,
  output logic [1:0] o_select,
  output logic       o_timer_toggle,
  output logic       o_sw_toggle,
  output logic       o_timer_add_one,
  output logic       o_timer_add_ten,
  output logic       o_blank,
  output logic       o_alert
);

  localparam int unsigned IDLE_W  = $clog2(IDLE_TIMEOUT_MS + 1);
  localparam int unsigned ALERT_W = $clog2(ALERT_MS + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_MS + 1);
  localparam int unsigned N_EDGE  = 5;

  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT_MS - 1);
  localparam logic [ALERT_W-1:0] ALERT_LAST = ALERT_W'(ALERT_MS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

  state_t             r_state, w_state_next;
  logic [1:0]         r_select, w_select_next;
  strobes_t           r_stb, w_stb_next;
  logic               r_blank, w_blank_next;
  logic               r_alert, w_alert_next;
  logic [IDLE_W-1:0]  r_idle_cnt, w_idle_next;
  logic [ALERT_W-1:0] r_alert_cnt, w_alert_cnt_next;
  logic [BLINK_W-1:0] r_blink_cnt, w_blink_next;

  logic [N_EDGE-1:0]  w_levels, w_edges;
  btn_edges_t         w_btn;
  logic               w_any_btn, w_exp_edge, w_idle_ok, w_route_ok, w_stay_alert;

  assign w_levels = {i_timer_expired, i_add_ten_btn, i_add_one_btn, i_toggle_btn, i_select_btn};

  for (genvar g = 0; g < N_EDGE; g++) begin : g_edge
    mode_controller_edge_pulse u_edge (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_level  (w_levels[g]),
      .o_edge_c (w_edges[g])
    );
  end

  assign w_btn      = btn_edges_t'({w_edges[0], w_edges[1], w_edges[2], w_edges[3]});
  assign w_exp_edge = w_edges[4];
  assign w_any_btn  = |w_btn;
  assign w_idle_ok  = (r_state == ST_MODE_24) ||
                      ((r_state == ST_MODE_TIMER) && !i_timer_running);
  // Expiry entering ALERT swallows every button edge of the same cycle
  assign w_route_ok = (r_state != ST_ALERT) && !w_exp_edge;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_MODE_12;
      r_select    <= SEL_MODE_12;
      r_stb       <= '0;
      r_blank     <= 1'b0;
      r_alert     <= 1'b0;
      r_idle_cnt  <= '0;
      r_alert_cnt <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_select    <= w_select_next;
      r_stb       <= w_stb_next;
      r_blank     <= w_blank_next;
      r_alert     <= w_alert_next;
      r_idle_cnt  <= w_idle_next;
      r_alert_cnt <= w_alert_cnt_next;
      r_blink_cnt <= w_blink_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ALERT: begin
        if (w_any_btn || (i_khz_tick && (r_alert_cnt == ALERT_LAST)))
          w_state_next = ST_MODE_TIMER;
      end
      default: begin
        if (w_exp_edge)
          w_state_next = ST_ALERT;
        else if (w_btn.sel)
          w_state_next = advance_mode(r_state);
        else if (w_idle_ok && !w_any_btn && i_khz_tick && (r_idle_cnt == IDLE_LAST))
          w_state_next = ST_MODE_12;
      end
    endcase
  end

  always_comb begin
    w_select_next    = select_of(w_state_next);
    w_alert_next     = (w_state_next == ST_ALERT);
    w_stay_alert     = (r_state == ST_ALERT) && (w_state_next == ST_ALERT);
    w_stb_next       = '0;
    w_blank_next     = 1'b0;
    w_idle_next      = '0;
    w_alert_cnt_next = '0;
    w_blink_next     = '0;

    // Toggle follows the pre-transition mode, even when select advances it
    if (w_route_ok) begin
      w_stb_next.timer_toggle  = w_btn.toggle && (r_state == ST_MODE_TIMER);
      w_stb_next.sw_toggle     = w_btn.toggle && (r_state == ST_MODE_SW);
      w_stb_next.timer_add_one = w_btn.add_one && (r_state == ST_MODE_TIMER) && !i_timer_running;
      w_stb_next.timer_add_ten = w_btn.add_ten && (r_state == ST_MODE_TIMER) && !i_timer_running;
    end

    if (w_stay_alert) begin
      w_blank_next     = r_blank;
      w_alert_cnt_next = r_alert_cnt;
      w_blink_next     = r_blink_cnt;
      if (i_khz_tick) begin
        if (r_alert_cnt != ALERT_LAST) w_alert_cnt_next = r_alert_cnt + ALERT_W'(1);
        if (r_blink_cnt == BLINK_LAST) begin
          w_blink_next = '0;
          w_blank_next = ~r_blank;
        end else begin
          w_blink_next = r_blink_cnt + BLINK_W'(1);
        end
      end
    end else if (w_state_next == ST_ALERT) begin
      w_blank_next = 1'b1;
    end

    if ((w_state_next == r_state) && !w_any_btn && w_idle_ok) begin
      w_idle_next = r_idle_cnt;
      if (i_khz_tick && (r_idle_cnt != IDLE_LAST)) w_idle_next = r_idle_cnt + IDLE_W'(1);
    end
  end

  assign o_select        = r_select;
  assign o_timer_toggle  = r_stb.timer_toggle;
  assign o_sw_toggle     = r_stb.sw_toggle;
  assign o_timer_add_one = r_stb.timer_add_one;
  assign o_timer_add_ten = r_stb.timer_add_ten;
  assign o_blank         = r_blank;
  assign o_alert         = r_alert;

endmodule

// File: tb/tb_mode_controller.sv
// Scoreboard bench for mode_controller: stimulus queues each expected output change
// with its cycle; a negedge monitor pops and compares whenever the outputs change.
module tb_mode_controller;

  localparam logic [1:0] S12 = 2'b00;
  localparam logic [1:0] S24 = 2'b01;
  localparam logic [1:0] STM = 2'b10;
  localparam logic [1:0] SSW = 2'b11;
  localparam logic [3:0] NO_STB  = 4'b0000;
  localparam logic [3:0] STB_TT  = 4'b1000;
  localparam logic [3:0] STB_SW  = 4'b0100;
  localparam logic [3:0] STB_A10 = 4'b0001;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0, sel_b = 1'b0, tog_b = 1'b0, one_b = 1'b0, ten_b = 1'b0;
  logic run = 1'b0, expd = 1'b0;
  logic [1:0] sel;
  logic tt, swt, a1, a10, blank, alert;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [7:0] mon_v;
  logic [7:0] mon_prev = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mode_controller #(
    .IDLE_TIMEOUT_MS (20),
    .ALERT_MS        (10),
    .BLINK_MS        (2)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_khz_tick      (tick),
    .i_select_btn    (sel_b),
    .i_toggle_btn    (tog_b),
    .i_add_one_btn   (one_b),
    .i_add_ten_btn   (ten_b),
    .i_timer_running (run),
    .i_timer_expired (expd),
    .o_select        (sel),
    .o_timer_toggle  (tt),
    .o_sw_toggle     (swt),
    .o_timer_add_one (a1),
    .o_timer_add_ten (a10),
    .o_blank         (blank),
    .o_alert         (alert)
  );

  function automatic logic [7:0] vec(logic [1:0] s, logic [3:0] stb, logic bl, logic al);
    return {s, stb, bl, al};
  endfunction

  // Monitor: every change of the output vector must match the next queued expectation
  always @(negedge clk) begin
    mon_v = {sel, tt, swt, a1, a10, blank, alert};
    if (mon_v !== mon_prev) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%b expected no change", cyc, mon_v);
      end else begin
        mon_e = sb_q.pop_front();
        if ((mon_e.v !== mon_v) || (mon_e.cyc != cyc)) begin
          n_fail++;
          $display("FAIL output_event got=%b@%0d expected=%b@%0d", mon_v, cyc, mon_e.v, mon_e.cyc);
        end
      end
      mon_prev = mon_v;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dc, input logic [7:0] v);
    exp_t e;
    e.cyc = cyc + dc;
    e.v   = v;
    sb_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [7:0] v);
    logic [7:0] got;
    got = {sel, tt, swt, a1, a10, blank, alert};
    n_tests++;
    if (got !== v) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b", name, got, v);
    end
  endtask

  task automatic set_in(input int idx, input logic val);
    case (idx)
      0: sel_b = val;
      1: tog_b = val;
      2: one_b = val;
      3: ten_b = val;
      default: expd = val;
    endcase
  endtask

  task automatic press(input int idx);
    set_in(idx, 1'b1);
    step(2);
    set_in(idx, 1'b0);
    step(2);
  endtask

  task automatic press_sel(input logic [1:0] new_sel);
    expect_at(1, vec(new_sel, NO_STB, 1'b0, 1'b0));
    press(0);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
    end
  endtask

  initial begin
    // Reset with select held high across release: no edge must appear
    sel_b = 1'b1;
    #1 rst = 1'b1;
    step(3);
    check_now("reset_state", vec(S12, NO_STB, 1'b0, 1'b0));
    rst = 1'b0;
    step(3);
    sel_b = 1'b0;
    step(2);
    check_now("held_through_reset", vec(S12, NO_STB, 1'b0, 1'b0));

    // 1: mode cycle
    press_sel(S24);
    press_sel(STM);
    press_sel(SSW);
    press_sel(S12);

    // 2: add strobes gated by timer_running
    press_sel(S24);
    press_sel(STM);
    expect_at(1, vec(STM, STB_A10, 1'b0, 1'b0));
    expect_at(2, vec(STM, NO_STB, 1'b0, 1'b0));
    press(3);
    run = 1'b1;
    step(1);
    press(2);
    check_now("add_one_while_running", vec(STM, NO_STB, 1'b0, 1'b0));

    // 3: toggle routing, then same-cycle select+toggle, then dropped toggle
    run = 1'b0;
    press_sel(SSW);
    expect_at(1, vec(SSW, STB_SW, 1'b0, 1'b0));
    expect_at(2, vec(SSW, NO_STB, 1'b0, 1'b0));
    press(1);
    expect_at(1, vec(S12, STB_SW, 1'b0, 1'b0));
    expect_at(2, vec(S12, NO_STB, 1'b0, 1'b0));
    sel_b = 1'b1; tog_b = 1'b1;
    step(2);
    sel_b = 1'b0; tog_b = 1'b0;
    step(2);
    press(1);
    check_now("toggle_in_12", vec(S12, NO_STB, 1'b0, 1'b0));

    // 4: expiry beats a same-cycle toggle; blink and self-timed exit
    press_sel(S24);
    press_sel(STM);
    press_sel(SSW);
    expect_at(1, vec(STM, NO_STB, 1'b1, 1'b1));
    expd = 1'b1; tog_b = 1'b1;
    step(2);
    tog_b = 1'b0;
    step(2);
    for (int t = 1; t <= 10; t++) begin
      if (t == 10)
        expect_at(1, vec(STM, NO_STB, 1'b0, 1'b0));
      else if ((t % 2) == 0)
        expect_at(1, vec(STM, NO_STB, ((t % 4) == 0), 1'b1));
      tick_n(1);
    end

    // 5: button press during alert is consumed
    expd = 1'b0;
    step(2);
    expect_at(1, vec(STM, NO_STB, 1'b1, 1'b1));
    expd = 1'b1;
    step(2);
    tick_n(1);
    expect_at(1, vec(STM, NO_STB, 1'b0, 1'b1));
    tick_n(2);
    expect_at(1, vec(STM, NO_STB, 1'b0, 1'b0));
    press(2);
    check_now("alert_exit_by_press", vec(STM, NO_STB, 1'b0, 1'b0));

    // 6: idle timeout from MODE_24, and a press restarting it
    expd = 1'b0;
    press_sel(SSW);
    press_sel(S12);
    press_sel(S24);
    for (int t = 1; t <= 20; t++) begin
      if (t == 20) expect_at(1, vec(S12, NO_STB, 1'b0, 1'b0));
      tick_n(1);
    end
    press_sel(S24);
    tick_n(14);
    press(1);
    tick_n(6);
    check_now("idle_restarted_by_press", vec(S24, NO_STB, 1'b0, 1'b0));
    tick_n(13);
    check_now("idle_one_before_timeout", vec(S24, NO_STB, 1'b0, 1'b0));
    expect_at(1, vec(S12, NO_STB, 1'b0, 1'b0));
    tick_n(1);

    // Async reset in the middle of an alert
    press_sel(S24);
    press_sel(STM);
    expect_at(1, vec(STM, NO_STB, 1'b1, 1'b1));
    expd = 1'b1;
    step(2);
    tick_n(1);
    expect_at(0, vec(S12, NO_STB, 1'b0, 1'b0));
    rst = 1'b1;
    #1;
    check_now("reset_mid_alert", vec(S12, NO_STB, 1'b0, 1'b0));
    step(2);
    rst = 1'b0;
    step(4);
    check_now("expired_held_through_reset", vec(S12, NO_STB, 1'b0, 1'b0));

    step(3);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
